// File: rtl/skew_delay_bank.sv
// Per-lane {valid,data} delay lines with lane-dependent depth (skew or deskew).
// Latency: lane k is D_k enabled cycles, D_k = BASE + k*STEP (MODE=0) or BASE + (CHANNELS-1-k)*STEP (MODE=1).
// Backpressure: none; en low freezes every stage and drops the inputs, clr flushes all stages.
module skew_delay_bank #(
    parameter int CHANNELS = 4,
    parameter int BITS     = 32,
    parameter int BASE     = 1,
    parameter int STEP     = 1,
    parameter int MODE     = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     clr,
    input  logic [CHANNELS-1:0]      in_valid,
    input  logic [CHANNELS*BITS-1:0] in_data,
    output logic [CHANNELS-1:0]      out_valid,
    output logic [CHANNELS*BITS-1:0] out_data,
    output logic                     busy
);

    // Per-lane "anything in flight" flags, reduced into busy below.
    logic [CHANNELS-1:0] lane_busy;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        // Depth of this lane; deskew mode mirrors the index so the last lane is shortest.
        localparam int D = (MODE == 0) ? (BASE + k * STEP)
                                       : (BASE + (CHANNELS - 1 - k) * STEP);

        logic [D-1:0]    vld_q;
        logic [D-1:0]    vld_d;
        logic [BITS-1:0] dat_q [D];
        logic [BITS-1:0] dat_d [D];

        // Next-state: clr wipes the lane, en shifts it by one stage, otherwise hold.
        always_comb begin
            vld_d = vld_q;
            dat_d = dat_q;
            if (clr) begin
                vld_d = '0;
                for (int s = 0; s < D; s++) begin
                    dat_d[s] = '0;
                end
            end else if (en) begin
                // Bubbles enter with zero data so out_data is zero whenever out_valid is low.
                vld_d[0] = in_valid[k];
                dat_d[0] = in_valid[k] ? in_data[k*BITS +: BITS] : '0;
                for (int s = 1; s < D; s++) begin
                    vld_d[s] = vld_q[s-1];
                    dat_d[s] = dat_q[s-1];
                end
            end
        end

        // Stage registers; reset empties the lane asynchronously.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
                for (int s = 0; s < D; s++) begin
                    dat_q[s] <= '0;
                end
            end else begin
                vld_q <= vld_d;
                for (int s = 0; s < D; s++) begin
                    dat_q[s] <= dat_d[s];
                end
            end
        end

        assign out_valid[k]               = vld_q[D-1];
        assign out_data[k*BITS +: BITS]   = dat_q[D-1];
        assign lane_busy[k]               = |vld_q;
    end

    assign busy = |lane_busy;

endmodule

// File: tb/tb_skew_delay_bank.sv
// Bench for skew_delay_bank: skew, deskew and STEP=0 instances share one stimulus stream.
// Expected outputs come from a history of accepted samples indexed by enabled-edge count.
// Each scenario task drives stimulus and compares outputs inline.
module tb_skew_delay_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic [3:0]  in_valid;
    logic [31:0] in_data;

    logic [3:0]  ov0, ov1, ov2;
    logic [31:0] od0, od1, od2;
    logic        b0, b1, b2;

    always #5 clk = ~clk;

    skew_delay_bank #(.CHANNELS(4), .BITS(8), .BASE(1), .STEP(1), .MODE(0)) u_skew (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov0), .out_data(od0), .busy(b0));

    skew_delay_bank #(.CHANNELS(4), .BITS(8), .BASE(1), .STEP(1), .MODE(1)) u_deskew (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov1), .out_data(od1), .busy(b1));

    skew_delay_bank #(.CHANNELS(4), .BITS(8), .BASE(2), .STEP(0), .MODE(0)) u_flat (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov2), .out_data(od2), .busy(b2));

    logic [110:0] act_all;
    assign act_all = {b2, ov2, od2, b1, ov1, od1, b0, ov0, od0};

    int n_checks = 0;
    int n_pass   = 0;

    // Reference history: what was accepted on each enabled edge; flush_n marks dead history.
    bit         acc_v [0:4095][0:3];
    logic [7:0] acc_d [0:4095][0:3];
    int         n       = 0;
    int         flush_n = 0;

    function automatic int dly(input int inst, input int k);
        if (inst == 0) return 1 + k;
        if (inst == 1) return 1 + (3 - k);
        return 2;
    endfunction

    // A sample accepted at enabled edge t is visible on lane k after edge t+D-1 and
    // occupies the lane for edges t..t+D-1.
    function automatic logic [110:0] expected_all();
        logic [110:0] r;
        logic         b;
        logic [3:0]   v;
        logic [31:0]  d;
        int           dd;
        int           idx;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            b = 1'b0; v = '0; d = '0;
            for (int k = 0; k < 4; k++) begin
                dd = dly(i, k);
                for (int j = 0; j < dd; j++) begin
                    idx = n - j;
                    if (idx > flush_n && acc_v[idx][k]) begin
                        b = 1'b1;
                        if (j == dd - 1) begin
                            v[k]        = 1'b1;
                            d[k*8 +: 8] = acc_d[idx][k];
                        end
                    end
                end
            end
            r[i*37 +: 37] = {b, v, d};
        end
        return r;
    endfunction

    task automatic drive_edge(input logic e, input logic c, input logic [3:0] v, input logic [31:0] d);
        en = e; clr = c; in_valid = v; in_data = d;
        @(posedge clk);
        if (c) begin
            flush_n = n;
        end else if (e) begin
            n++;
            for (int k = 0; k < 4; k++) begin
                acc_v[n][k] = v[k];
                acc_d[n][k] = d[k*8 +: 8];
            end
        end
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) drive_edge(1'b1, 1'b0, 4'b0000, $urandom);
    endtask

    task automatic test_reset();
        n_checks++;
        if (act_all !== '0) $display("FAIL reset_outputs act=%h exp=0", act_all);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (act_all !== expected_all()) $display("FAIL reset_release act=%h exp=%h", act_all, expected_all());
        else n_pass++;
    endtask

    task automatic test_skew();
        logic [3:0] v;
        logic [7:0] dl;
        drive_edge(1'b1, 1'b0, 4'b1111, 32'h44332211);
        for (int e = 1; e <= 5; e++) begin
            if (e > 1) drive_edge(1'b1, 1'b0, 4'b0000, $urandom);
            v  = (e <= 4) ? 4'(1 << (e - 1)) : 4'b0000;
            dl = (e <= 4) ? 8'(8'h11 * e) : 8'h00;
            n_checks++;
            if (ov0 !== v) $display("FAIL skew_valid edge=%0d act=%b exp=%b", e, ov0, v);
            else n_pass++;
            if (e <= 4) begin
                n_checks++;
                if (od0[(e-1)*8 +: 8] !== dl) $display("FAIL skew_data edge=%0d act=%h exp=%h", e, od0[(e-1)*8 +: 8], dl);
                else n_pass++;
            end
            n_checks++;
            if (act_all !== expected_all()) $display("FAIL skew_model edge=%0d act=%h exp=%h", e, act_all, expected_all());
            else n_pass++;
        end
    endtask

    task automatic test_deskew();
        logic [3:0] v;
        drive_edge(1'b1, 1'b0, 4'b1111, 32'h44332211);
        for (int e = 1; e <= 4; e++) begin
            if (e > 1) drive_edge(1'b1, 1'b0, 4'b0000, $urandom);
            v = 4'(1 << (4 - e));
            n_checks++;
            if (ov1 !== v) $display("FAIL deskew_valid edge=%0d act=%b exp=%b", e, ov1, v);
            else n_pass++;
            n_checks++;
            if (act_all !== expected_all()) $display("FAIL deskew_model edge=%0d act=%h exp=%h", e, act_all, expected_all());
            else n_pass++;
        end
        n_checks++;
        if (od1[7:0] !== 8'h11) $display("FAIL deskew_lane0_data act=%h exp=11", od1[7:0]);
        else n_pass++;
        idle(2);
    endtask

    task automatic test_stall();
        drive_edge(1'b1, 1'b0, 4'b0100, 32'h00AA0000);
        for (int c = 0; c < 5; c++) begin
            drive_edge(1'b0, 1'b0, 4'($urandom), $urandom);
            n_checks++;
            if (b0 !== 1'b1 || ov0[2] !== 1'b0)
                $display("FAIL stall_hold cyc=%0d act_busy=%b act_v2=%b exp_busy=1 exp_v2=0", c, b0, ov0[2]);
            else n_pass++;
            n_checks++;
            if (act_all !== expected_all()) $display("FAIL stall_model cyc=%0d act=%h exp=%h", c, act_all, expected_all());
            else n_pass++;
        end
        drive_edge(1'b1, 1'b0, 4'b0000, 32'h0);
        n_checks++;
        if (ov0[2] !== 1'b0) $display("FAIL stall_early act=%b exp=0", ov0[2]);
        else n_pass++;
        drive_edge(1'b1, 1'b0, 4'b0000, 32'h0);
        n_checks++;
        if (ov0[2] !== 1'b1 || od0[23:16] !== 8'hAA)
            $display("FAIL stall_release act_v=%b act_d=%h exp_v=1 exp_d=aa", ov0[2], od0[23:16]);
        else n_pass++;
        idle(4);
    endtask

    task automatic test_bubble();
        drive_edge(1'b1, 1'b0, 4'b1110, 32'h332211FF);
        n_checks++;
        if (ov0[0] !== 1'b0 || od0[7:0] !== 8'h00)
            $display("FAIL bubble_zero act_v=%b act_d=%h exp_v=0 exp_d=00", ov0[0], od0[7:0]);
        else n_pass++;
        for (int c = 0; c < 5; c++) begin
            drive_edge(1'b1, 1'b0, 4'b0000, 32'hFFFFFFFF);
            n_checks++;
            if (act_all !== expected_all()) $display("FAIL bubble_model cyc=%0d act=%h exp=%h", c, act_all, expected_all());
            else n_pass++;
        end
    endtask

    task automatic test_flush();
        for (int c = 1; c <= 4; c++) drive_edge(1'b1, 1'b0, 4'b1111, {4{8'(c)}});
        drive_edge(1'b0, 1'b1, 4'b1111, {4{8'h05}});
        n_checks++;
        if (act_all !== '0) $display("FAIL flush_clear act=%h exp=0", act_all);
        else n_pass++;
        for (int c = 5; c <= 12; c++) begin
            drive_edge(1'b1, 1'b0, (c <= 8) ? 4'b1111 : 4'b0000, {4{8'(c)}});
            n_checks++;
            if (act_all !== expected_all()) $display("FAIL flush_after cyc=%0d act=%h exp=%h", c, act_all, expected_all());
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic e, c;
        for (int i = 0; i < 300; i++) begin
            e = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 19) == 0);
            drive_edge(e, c, 4'($urandom), $urandom);
            n_checks++;
            if (act_all !== expected_all()) $display("FAIL random_stream cyc=%0d act=%h exp=%h", i, act_all, expected_all());
            else n_pass++;
        end
        for (int i = 0; i < 6; i++) drive_edge(1'b1, 1'b0, 4'b1111, $urandom);
        n_checks++;
        if (ov0 !== 4'b1111 || ov2 !== 4'b1111) $display("FAIL full_throughput act0=%b act2=%b exp=1111", ov0, ov2);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        n_checks++;
        if (b0 !== 1'b1) $display("FAIL async_pre_busy act=%b exp=1", b0);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        flush_n = n;
        n_checks++;
        if (act_all !== '0) $display("FAIL async_immediate act=%h exp=0", act_all);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (act_all !== '0) $display("FAIL async_held act=%h exp=0", act_all);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        drive_edge(1'b1, 1'b0, 4'b1111, 32'hD4C3B2A1);
        for (int e = 1; e <= 5; e++) begin
            if (e > 1) drive_edge(1'b1, 1'b0, 4'b0000, $urandom);
            n_checks++;
            if (ov0[3] !== (e == 4)) $display("FAIL async_latency edge=%0d act=%b exp=%b", e, ov0[3], (e == 4));
            else n_pass++;
            n_checks++;
            if (act_all !== expected_all()) $display("FAIL async_model edge=%0d act=%h exp=%h", e, act_all, expected_all());
            else n_pass++;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        clr      = 1'b0;
        in_valid = '0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_skew();
        test_deskew();
        test_stall();
        test_bubble();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
